hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 153 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit with a multi-cycle scoreboard: forwarding, load-use, RAW/WAW and capacity stalls, flushes.
// Ports: D/E/M/W register indices in, ForwardAE/BE, StallF/D, FlushD/E, McFull, McErr out; StallCnt/FlushCnt with HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int MC_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] RdD,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic [1:0]    ResultSrcE,
  input  logic          PCSrcE,
  input  logic          McIssueD,
  input  logic          McIssueE,
  input  logic          McDoneW,
  input  logic [AW-1:0] McRdW,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic          McFull,
  output logic          McErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]   StallCnt,
  output logic [31:0]   FlushCnt
`endif
);

  localparam int NR = 2 ** AW;
  localparam int CW = $clog2(MC_DEPTH + 1);
  localparam logic [CW-1:0] MAXC = CW'(MC_DEPTH);

  logic [NR-1:0] pending;
  logic [NR-1:0] pendNext;
  logic [CW-1:0] mcCount;
  logic [CW-1:0] cntNext;
  logic          errEv;
  logic          unusedSrc;

  assign unusedSrc = ResultSrcE[1];

  function automatic logic [1:0] fwd(
    input logic [AW-1:0] rs
  );
    logic mHit;
    logic wHit;
    logic [1:0] sel;
    mHit = RegWriteM && (RdM == rs) && (rs != '0);
    wHit = RegWriteW && (RdW == rs) && (rs != '0);
    sel  = 2'b00;
    unique case (1'b1)
      mHit:          sel = 2'b10;
      wHit && !mHit: sel = 2'b01;
      default:       sel = 2'b00;
    endcase
    return sel;
  endfunction

  assign ForwardAE = fwd(Rs1E);
  assign ForwardBE = fwd(Rs2E);

  logic lwStall;
  logic scbStall;
  logic fullStall;
  logic hz;
  logic p1;
  logic p2;
  logic pd;

  assign lwStall = ResultSrcE[0] && (RdE != '0)
                && ((Rs1D == RdE) || (Rs2D == RdE));

  // A result retiring this cycle is visible through the write-first regfile.
  assign p1 = pending[Rs1D] && !(McDoneW && (McRdW == Rs1D));
  assign p2 = pending[Rs2D] && !(McDoneW && (McRdW == Rs2D));
  assign pd = pending[RdD]  && !(McDoneW && (McRdW == RdD));

  assign scbStall  = p1 || p2 || pd;
  assign McFull    = (mcCount == MAXC);
  assign fullStall = McIssueD && McFull && !McDoneW;
  assign hz        = lwStall || scbStall || fullStall;

  assign StallF = hz && !PCSrcE;
  assign StallD = hz && !PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = hz || PCSrcE;

  // Clear before set so a same-index issue/done leaves the bit set.
  always_comb begin
    pendNext = pending;
    if (McDoneW) pendNext[McRdW] = 1'b0;
    if (McIssueE && (RdE != '0)) pendNext[RdE] = 1'b1;
    pendNext[0] = 1'b0;
  end

  logic incOnly;
  logic decOnly;
  assign incOnly = McIssueE && !McDoneW;
  assign decOnly = McDoneW && !McIssueE;

  always_comb begin
    cntNext = mcCount;
    errEv   = McDoneW && (mcCount == '0);
    unique case (1'b1)
      incOnly: begin
        if (mcCount == MAXC) errEv = 1'b1;
        else cntNext = mcCount + 1'b1;
      end
      decOnly: begin
        if (mcCount != '0) cntNext = mcCount - 1'b1;
      end
      default: cntNext = mcCount;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      mcCount <= '0;
      McErr   <= 1'b0;
    end else begin
      pending <= pendNext;
      mcCount <= cntNext;
      if (errEv) McErr <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && (StallCnt != 32'hFFFF_FFFF))
        StallCnt <= StallCnt + 32'd1;
      if (FlushE && (FlushCnt != 32'hFFFF_FFFF))
        FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an expected-result queue.
// Vector order: {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, McFull, McErr}.
module tb_hazard_scoreboard;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, McRdW;
  logic          RegWriteM, RegWriteW, PCSrcE;
  logic [1:0]    ResultSrcE;
  logic          McIssueD, McIssueE, McDoneW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, FlushE, McFull, McErr;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   StallCnt, FlushCnt;
`endif

  hazard_scoreboard #(.AW(AW), .MC_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .McIssueD(McIssueD), .McIssueE(McIssueE),
    .McDoneW(McDoneW), .McRdW(McRdW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE),
    .McFull(McFull), .McErr(McErr)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  function automatic logic [9:0] E(
    input logic [1:0] fa, input logic [1:0] fb,
    input logic sf, input logic sd, input logic fd,
    input logic fe, input logic full, input logic err
  );
    return {fa, fb, sf, sd, fd, fe, full, err};
  endfunction

  task automatic idle();
    Rs1D = '0; Rs2D = '0; RdD = '0;
    Rs1E = '0; Rs2E = '0; RdE = '0;
    RdM = '0; RdW = '0; McRdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; ResultSrcE = 2'b00;
    McIssueD = 1'b0; McIssueE = 1'b0; McDoneW = 1'b0;
  endtask

  task automatic chkNow();
    exp_t e;
    logic [9:0] obs;
    while (expQ.size() > 0) begin
      e   = expQ.pop_front();
      obs = {ForwardAE, ForwardBE, StallF, StallD,
             FlushD, FlushE, McFull, McErr};
      nChecks++;
      assert (obs === e.v) else begin
        nFails++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step(input string tag, input logic [9:0] v);
    expQ.push_back('{tag, v});
    @(negedge clk);
    chkNow();
    @(posedge clk);
    #1;
  endtask

  task automatic rstStep(input string tag);
    idle();
    rst_n = 1'b0;
    #1;
    expQ.push_back('{tag, E(0, 0, 0, 0, 0, 0, 0, 0)});
    chkNow();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [9:0] STL = 10'b00_00_1101_00;

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    expQ.push_back('{"reset", E(0, 0, 0, 0, 0, 0, 0, 0)});
    chkNow();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    idle(); Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    step("fwdM", E(2, 0, 0, 0, 0, 0, 0, 0));
    idle(); Rs1E = 0; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    step("fwdZero", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); Rs1E = 6; Rs2E = 6; RdM = 6; RdW = 6; RegWriteW = 1;
    step("fwdW", E(1, 1, 0, 0, 0, 0, 0, 0));
    idle(); Rs1E = 3; Rs2E = 4; RdM = 4; RegWriteM = 1;
    RdW = 3; RegWriteW = 1;
    step("fwdMix", E(1, 2, 0, 0, 0, 0, 0, 0));

    idle(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    step("lwStall", E(0, 0, 1, 1, 0, 1, 0, 0));
    idle(); ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
    step("lwR0", E(0, 0, 0, 0, 0, 0, 0, 0));

    idle(); McIssueE = 1; RdE = 9;
    step("issue9", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); Rs1D = 9;
    step("raw9", STL);
    idle(); Rs1D = 9;
    step("raw9b", STL);
    idle(); Rs1D = 9; McDoneW = 1; McRdW = 9;
    step("done9", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); Rs1D = 9;
    step("clear9", E(0, 0, 0, 0, 0, 0, 0, 0));

    idle(); McIssueE = 1; RdE = 8;
    step("issue8", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); McIssueE = 1; RdE = 8; McDoneW = 1; McRdW = 8; Rs2D = 8;
    step("issDone8", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); Rs2D = 8;
    step("setWins8", STL);
    idle(); McDoneW = 1; McRdW = 8;
    step("done8", E(0, 0, 0, 0, 0, 0, 0, 0));

    idle(); McIssueE = 1; RdE = 3;
    step("issue3", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); McIssueE = 1; RdE = 4;
    step("issue4", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle();
    step("full", E(0, 0, 0, 0, 0, 0, 1, 0));
    idle(); McIssueD = 1;
    step("fullStall", E(0, 0, 1, 1, 0, 1, 1, 0));
    idle(); McIssueD = 1; McDoneW = 1; McRdW = 3;
    step("fullDone", E(0, 0, 0, 0, 0, 0, 1, 0));
    idle(); RdD = 4;
    step("wawStall", STL);
    idle(); RdD = 4; PCSrcE = 1;
    step("redirect", E(0, 0, 0, 0, 1, 1, 0, 0));
    idle(); McDoneW = 1; McRdW = 4;
    step("done4", E(0, 0, 0, 0, 0, 0, 0, 0));

    idle(); McDoneW = 1; McRdW = 1;
    step("underflow", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle();
    step("errSet", E(0, 0, 0, 0, 0, 0, 0, 1));
    idle(); Rs1D = 1;
    step("errHold", E(0, 0, 0, 0, 0, 0, 0, 1));

    idle(); McIssueE = 1; RdE = 5;
    step("issue5", E(0, 0, 0, 0, 0, 0, 0, 1));
    idle(); Rs1D = 5;
    step("raw5", E(0, 0, 1, 1, 0, 1, 0, 1));
    rstStep("midRst");
    idle(); Rs1D = 5;
    step("afterRst", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); McDoneW = 1; McRdW = 5;
    step("staleDone", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle();
    step("staleErr", E(0, 0, 0, 0, 0, 0, 0, 1));

    rstStep("rst2");
    idle(); McIssueE = 1; RdE = 1;
    step("satIss1", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); McIssueE = 1; RdE = 2;
    step("satIss2", E(0, 0, 0, 0, 0, 0, 0, 0));
    idle(); McIssueE = 1; RdE = 6;
    step("satIss3", E(0, 0, 0, 0, 0, 0, 1, 0));
    idle();
    step("satErr", E(0, 0, 0, 0, 0, 0, 1, 1));

`ifdef HAZARD_PERF_CNT_EN
    rstStep("rst3");
    for (int i = 0; i < 3; i++) begin
      idle(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
      step("perfStall", STL);
    end
    idle();
    @(negedge clk);
    nChecks++;
    assert (StallCnt === 32'd3) else begin
      nFails++;
      $error("FAIL stallCnt: observed %0d expected 3", StallCnt);
    end
    nChecks++;
    assert (FlushCnt === 32'd3) else begin
      nFails++;
      $error("FAIL flushCnt: observed %0d expected 3", FlushCnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
